ras_ckpt_ctl: RTL and testbench
===============================

# ras_ckpt_ctl

Checkpoint and repair controller for the fetch-stage return address stack. It records the RAS pointer and top-of-stack value for every predicted branch in flight, retires those checkpoints in order, and sequences stack repair after a misprediction. Repair means restoring the pointer, rewriting the clobbered entry, and replaying the resolved branch's own push/pop. It sits between the fetch RAS and the branch resolution/retire logic, and it stalls fetch while repair runs.

## Interface
- DEPTH, 8: checkpoint queue entries (power of 2)
- TAG_W, 3: log2(DEPTH)
- PTR_W, 4: RAS pointer width (16-entry stack)
- DATA_W, 64: return address width

- clock  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- alloc_vld_i  in  1  fetch requests a checkpoint for a predicted branch
- alloc_ptr_i  in  PTR_W  RAS pointer before the branch's own update
- alloc_tos_i  in  DATA_W  top-of-stack data before the branch's update
- alloc_rdy_o  out  1  allocation accepted this cycle
- alloc_tag_o  out  TAG_W  tag given to the branch (current tail index)
- ret_vld_i  in  1  oldest in-flight branch retired; dequeue head
- mis_vld_i  in  1  branch mispredict resolved
- mis_tag_i  in  TAG_W  tag of the mispredicted branch
- mis_rasctl_i  in  2  true RAS action of that branch: 00 none, 01 push, 10 pop, 11 pop-then-push
- mis_raddr_i  in  DATA_W  return address for a call (push/popu)
- mis_rdy_o  out  1  mispredict accepted this cycle
- flush_i  in  1  full pipeline flush from retire
- rep_we_o  out  1  RAS entry write strobe
- rep_addr_o  out  PTR_W  RAS entry index to write
- rep_data_o  out  DATA_W  RAS entry data
- rep_vld_o  out  1  load rep_ptr_o into the RAS pointer (1-cycle pulse)
- rep_ptr_o  out  PTR_W  repaired RAS pointer
- stall_o  out  1  fetch stall while repair runs
- cnt_o  out  TAG_W+1  checkpoints in flight

## Operation
- **Queue storage:** circular queue, DEPTH entries of {ptr, tos}. Head, tail and count registers.
- **Allocation:**
  - alloc_rdy_o = (state==IDLE) & ~mis_vld_i & ~flush_i & (cnt_o<DEPTH).
  - On alloc_vld_i & alloc_rdy_o, write the entry at tail, then tail+1 mod DEPTH and count+1.
- **Retire:** ret_vld_i with count==0 is ignored. Otherwise head+1 and count-1.
- **Mispredict acceptance:**
  - mis_rdy_o = (state==IDLE) & ~flush_i.
  - The tag is valid only if ((mis_tag_i-head) mod DEPTH) < count. An invalid tag is ignored and the FSM does not leave IDLE.
- **Mispredict capture:** on acceptance, latch entry[mis_tag_i], mis_rasctl_i and mis_raddr_i. Truncate the queue: tail = mis_tag_i+1, count = ((mis_tag_i-head) mod DEPTH)+1. The branch's own entry is kept.
- **Repair FSM, states IDLE, RESTORE, FIX:**
  - IDLE -> RESTORE on an accepted mispredict.
  - RESTORE:
    - Write rep_we_o=1, rep_addr_o=saved ptr, rep_data_o=saved tos.
    - If rasctl is 00 or 10: also pulse rep_vld_o, then go to IDLE.
    - Otherwise go to FIX.
  - FIX:
    - push (01): write mis_raddr at saved ptr+1.
    - popu (11): write mis_raddr at saved ptr.
    - Pulse rep_vld_o, then go to IDLE.
  - rep_ptr_o by rasctl: 00 -> ptr, 01 -> ptr+1, 10 -> ptr-1, 11 -> ptr.
  - All pointer arithmetic is mod 2^PTR_W (wraps 15->0 and 0->15).
- **flush_i (highest priority):** head=tail=count=0 and FSM to IDLE. No rep_* strobe that cycle. An in-progress repair is abandoned.
- **Same-cycle events:**
  - ret and alloc: both applied, so count is unchanged.
  - ret and accepted mis: head advances, and count is recomputed from the new head. If mis_tag_i==head, count becomes 0.
  - A ret arriving during RESTORE/FIX is honoured.

## Timing
- Reset values: all queue pointers and count 0, state IDLE. Outputs: alloc_rdy_o=1, mis_rdy_o=1, alloc_tag_o=0, cnt_o=0, stall_o=0, rep_we_o=0, rep_vld_o=0, rep_addr_o=0, rep_data_o=0, rep_ptr_o=0.
- alloc_rdy_o, mis_rdy_o and alloc_tag_o are combinational. Every other output is registered or decoded from the state register.
- Mispredict accepted in cycle N:
  - RESTORE in N+1.
  - FIX (if needed) in N+2.
  - rep_vld_o in the last repair cycle.
  - stall_o=1 exactly in the RESTORE and FIX cycles.
- Repair latency is 1 cycle (none/pop) or 2 cycles (push/popu).
- Reset mid-repair returns everything to reset values immediately. No partial write strobe occurs after reset assertion.

## Test plan
- **Reset then fill:** 8 allocs with ptr 0..7. Tags are 0..7, cnt_o=8, and alloc_rdy_o=0 on the 9th request.
- **Retire with wrap:** 8 allocs, then 3 ret, then 3 allocs. Tags issued are 0,1,2 (wrap) and cnt_o=8. A ret on an empty queue leaves cnt_o=0.
- **Pop repair:** allocate tags 0..4, then mis_tag=2 with saved ptr=0, tos=0xA5, rasctl=10. Response:
  - RESTORE writes addr 0, data 0xA5.
  - rep_vld_o with rep_ptr_o=15.
  - cnt_o=3.
  - stall_o=1 for 1 cycle.
- **Push repair:** saved ptr=15, rasctl=01, raddr=0x1000. Response:
  - RESTORE writes addr 15.
  - FIX writes 0x1000 at addr 0.
  - rep_ptr_o=0.
  - stall_o=1 for 2 cycles.
- **Flush collisions:** flush_i in the RESTORE cycle gives no FIX, rep_vld_o=0, cnt_o=0 and IDLE. Simultaneous mis and alloc: the alloc is dropped (alloc_rdy_o=0).
- **Invalid tag:** mis_tag outside the in-flight range is ignored, with no state change and stall_o=0.

Source files
------------

// File: rtl/ras_ckpt_ctl.sv
// ras_ckpt_ctl
//   Checkpoint and repair controller for the fetch-stage return address stack.
//   Each predicted branch gets a checkpoint {RAS pointer, top-of-stack value}
//   in a circular queue. Checkpoints retire in order. On a misprediction the
//   queue is truncated behind the branch and a short repair sequence is run:
//   restore the clobbered entry, replay the branch's own push if any, then
//   reload the RAS pointer. Fetch is stalled while the repair runs.
//
// Ports
//   clock, reset      core clock, asynchronous active-high reset
//   alloc_vld_i       checkpoint request from fetch (alloc_ptr_i, alloc_tos_i)
//   alloc_rdy_o       request accepted this cycle (combinational)
//   alloc_tag_o       tag handed to the branch (tail index, combinational)
//   ret_vld_i         oldest in-flight branch retired
//   mis_vld_i         mispredict resolved (mis_tag_i, mis_rasctl_i, mis_raddr_i)
//   mis_rdy_o         mispredict accepted this cycle (combinational)
//   flush_i           full pipeline flush, highest priority
//   rep_we_o          RAS entry write strobe (rep_addr_o, rep_data_o)
//   rep_vld_o         load rep_ptr_o into the RAS pointer (one-cycle pulse)
//   stall_o           fetch stall while repair runs
//   cnt_o             checkpoints in flight
module ras_ckpt_ctl #(
    parameter int DEPTH  = 8,
    parameter int TAG_W  = 3,
    parameter int PTR_W  = 4,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alloc_vld_i,
    input  logic [PTR_W-1:0]  alloc_ptr_i,
    input  logic [DATA_W-1:0] alloc_tos_i,
    output logic              alloc_rdy_o,
    output logic [TAG_W-1:0]  alloc_tag_o,
    input  logic              ret_vld_i,
    input  logic              mis_vld_i,
    input  logic [TAG_W-1:0]  mis_tag_i,
    input  logic [1:0]        mis_rasctl_i,
    input  logic [DATA_W-1:0] mis_raddr_i,
    output logic              mis_rdy_o,
    input  logic              flush_i,
    output logic              rep_we_o,
    output logic [PTR_W-1:0]  rep_addr_o,
    output logic [DATA_W-1:0] rep_data_o,
    output logic              rep_vld_o,
    output logic [PTR_W-1:0]  rep_ptr_o,
    output logic              stall_o,
    output logic [TAG_W:0]    cnt_o
);

    localparam logic [TAG_W:0] DEPTH_C = DEPTH[TAG_W:0];

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESTORE = 2'd1,
        FIX     = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [PTR_W-1:0]  ptr_mem [DEPTH];
    logic [DATA_W-1:0] tos_mem [DEPTH];

    logic [TAG_W-1:0]  head, tail, head_nxt, mis_off;
    logic [TAG_W:0]    count, mis_cnt;
    logic              alloc_fire, ret_fire, mis_acc;

    logic [PTR_W-1:0]  sav_ptr;
    logic [DATA_W-1:0] sav_tos, sav_raddr;
    logic [1:0]        sav_ctl;

    // Pointer value the RAS must hold once the resolved branch's own action
    // has been replayed on top of the restored state.
    function automatic logic [PTR_W-1:0] repaired_ptr(input logic [PTR_W-1:0] p,
                                                     input logic [1:0] ctl);
        case (ctl)
            2'b01:   repaired_ptr = p + PTR_W'(1);
            2'b10:   repaired_ptr = p - PTR_W'(1);
            default: repaired_ptr = p;
        endcase
    endfunction

    assign alloc_rdy_o = (state == IDLE) & ~mis_vld_i & ~flush_i & (count < DEPTH_C);
    assign mis_rdy_o   = (state == IDLE) & ~flush_i;
    assign alloc_tag_o = tail;
    assign cnt_o       = count;

    assign alloc_fire = alloc_vld_i & alloc_rdy_o;
    assign ret_fire   = ret_vld_i & (count != '0) & ~flush_i;
    assign head_nxt   = head + TAG_W'(ret_fire);

    // Tag distance from head wraps naturally because DEPTH is 2**TAG_W.
    assign mis_off = mis_tag_i - head;
    assign mis_acc = mis_vld_i & mis_rdy_o & ({1'b0, mis_off} < count);

    // Kept range runs from the (possibly advanced) head up to the branch.
    // If the branch itself retires this cycle nothing is left in flight.
    assign mis_cnt = (ret_fire && (mis_tag_i == head)) ? '0
                   : {1'b0, mis_tag_i - head_nxt} + (TAG_W+1)'(1);

    // ---- queue control ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            sav_ctl <= '0;
        end else if (flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head <= head_nxt;
            if (mis_acc) begin
                tail    <= mis_tag_i + TAG_W'(1);
                count   <= mis_cnt;
                sav_ctl <= mis_rasctl_i;
            end else begin
                if (alloc_fire)
                    tail <= tail + TAG_W'(1);
                count <= count + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(ret_fire);
            end
        end
    end

    // ---- checkpoint storage and repair capture (data only) ----
    always_ff @(posedge clock) begin
        if (alloc_fire) begin
            ptr_mem[tail] <= alloc_ptr_i;
            tos_mem[tail] <= alloc_tos_i;
        end
        if (mis_acc) begin
            sav_ptr   <= ptr_mem[mis_tag_i];
            sav_tos   <= tos_mem[mis_tag_i];
            sav_raddr <= mis_raddr_i;
        end
    end

    // ---- repair FSM: state register ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // ---- repair FSM: next state ----
    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (mis_acc) state_nxt = RESTORE;
                // Only a replayed push (01/11) needs the extra FIX write.
                RESTORE: state_nxt = sav_ctl[0] ? FIX : IDLE;
                FIX:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // ---- repair FSM: outputs ----
    // Strobes are masked by flush so an abandoned repair never writes the RAS.
    always_comb begin
        rep_we_o   = 1'b0;
        rep_addr_o = '0;
        rep_data_o = '0;
        rep_vld_o  = 1'b0;
        rep_ptr_o  = '0;
        stall_o    = 1'b0;
        case (state)
            RESTORE: begin
                stall_o    = 1'b1;
                rep_we_o   = ~flush_i;
                rep_addr_o = sav_ptr;
                rep_data_o = sav_tos;
                rep_vld_o  = ~sav_ctl[0] & ~flush_i;
                rep_ptr_o  = repaired_ptr(sav_ptr, sav_ctl);
            end
            FIX: begin
                stall_o    = 1'b1;
                rep_we_o   = ~flush_i;
                // push lands above the restored entry; pop-then-push overwrites it
                rep_addr_o = (sav_ctl == 2'b01) ? sav_ptr + PTR_W'(1) : sav_ptr;
                rep_data_o = sav_raddr;
                rep_vld_o  = ~flush_i;
                rep_ptr_o  = repaired_ptr(sav_ptr, sav_ctl);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ras_ckpt_ctl.sv
module tb_ras_ckpt_ctl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        alloc_vld_i;
    logic [3:0]  alloc_ptr_i;
    logic [63:0] alloc_tos_i;
    logic        alloc_rdy_o;
    logic [2:0]  alloc_tag_o;
    logic        ret_vld_i;
    logic        mis_vld_i;
    logic [2:0]  mis_tag_i;
    logic [1:0]  mis_rasctl_i;
    logic [63:0] mis_raddr_i;
    logic        mis_rdy_o;
    logic        flush_i;
    logic        rep_we_o;
    logic [3:0]  rep_addr_o;
    logic [63:0] rep_data_o;
    logic        rep_vld_o;
    logic [3:0]  rep_ptr_o;
    logic        stall_o;
    logic [3:0]  cnt_o;

    ras_ckpt_ctl #(.DEPTH(8), .TAG_W(3), .PTR_W(4), .DATA_W(64)) dut (
        .clock(clock), .reset(reset),
        .alloc_vld_i(alloc_vld_i), .alloc_ptr_i(alloc_ptr_i), .alloc_tos_i(alloc_tos_i),
        .alloc_rdy_o(alloc_rdy_o), .alloc_tag_o(alloc_tag_o),
        .ret_vld_i(ret_vld_i),
        .mis_vld_i(mis_vld_i), .mis_tag_i(mis_tag_i), .mis_rasctl_i(mis_rasctl_i),
        .mis_raddr_i(mis_raddr_i), .mis_rdy_o(mis_rdy_o),
        .flush_i(flush_i),
        .rep_we_o(rep_we_o), .rep_addr_o(rep_addr_o), .rep_data_o(rep_data_o),
        .rep_vld_o(rep_vld_o), .rep_ptr_o(rep_ptr_o),
        .stall_o(stall_o), .cnt_o(cnt_o)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int          tag;
        logic [3:0]  ptr;
        logic [63:0] tos;
    } ent_t;

    typedef struct {
        logic        vld;
        logic [3:0]  addr;
        logic [63:0] data;
        logic [3:0]  ptr;
    } rep_t;

    ent_t q[$];       // checkpoints in flight, oldest first
    rep_t ex[$];      // one item per remaining repair cycle
    int   next_tag = 0;

    logic m_idle, m_alloc_rdy, m_mis_rdy, found;
    rep_t cur;
    ent_t fe;
    logic [3:0] rp;

    always @(negedge clock) begin
        if (reset) begin
            q.delete();
            ex.delete();
            next_tag = 0;
        end
        m_idle = (ex.size() == 0);
        if (!m_idle) cur = ex[0];
        else cur = '{vld: 1'b0, addr: 4'd0, data: 64'd0, ptr: 4'd0};
        m_alloc_rdy = m_idle && !mis_vld_i && !flush_i && (q.size() < 8);
        m_mis_rdy   = m_idle && !flush_i;

        chk("m_alloc_rdy", 64'(alloc_rdy_o), 64'(m_alloc_rdy));
        chk("m_mis_rdy",   64'(mis_rdy_o),   64'(m_mis_rdy));
        chk("m_tag",       64'(alloc_tag_o), 64'(next_tag));
        chk("m_cnt",       64'(cnt_o),       64'(q.size()));
        chk("m_stall",     64'(stall_o),     64'(!m_idle));
        chk("m_we",        64'(rep_we_o),    64'(!m_idle && !flush_i));
        chk("m_vld",       64'(rep_vld_o),   64'(!m_idle && cur.vld && !flush_i));
        chk("m_addr",      64'(rep_addr_o),  64'(cur.addr));
        chk("m_data",      rep_data_o,       cur.data);
        chk("m_ptr",       64'(rep_ptr_o),   64'(cur.ptr));

        if (!reset) begin
            if (flush_i) begin
                q.delete();
                ex.delete();
                next_tag = 0;
            end else begin
                found = 1'b0;
                if (m_mis_rdy && mis_vld_i)
                    foreach (q[k])
                        if (!found && q[k].tag == int'(mis_tag_i)) begin
                            found = 1'b1;
                            fe = q[k];
                        end
                if (ex.size() > 0) void'(ex.pop_front());
                if (ret_vld_i && q.size() > 0) void'(q.pop_front());
                if (alloc_vld_i && m_alloc_rdy) begin
                    q.push_back('{tag: next_tag, ptr: alloc_ptr_i, tos: alloc_tos_i});
                    next_tag = (next_tag + 1) % 8;
                end
                if (found) begin
                    while (q.size() > 0 && q[q.size()-1].tag != int'(mis_tag_i))
                        void'(q.pop_back());
                    next_tag = (int'(mis_tag_i) + 1) % 8;
                    case (mis_rasctl_i)
                        2'b01:   rp = fe.ptr + 4'd1;
                        2'b10:   rp = fe.ptr - 4'd1;
                        default: rp = fe.ptr;
                    endcase
                    ex.push_back('{vld: !mis_rasctl_i[0], addr: fe.ptr, data: fe.tos, ptr: rp});
                    if (mis_rasctl_i[0])
                        ex.push_back('{vld: 1'b1,
                                       addr: (mis_rasctl_i == 2'b01) ? fe.ptr + 4'd1 : fe.ptr,
                                       data: mis_raddr_i, ptr: rp});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle_in();
        alloc_vld_i  = 1'b0;
        alloc_ptr_i  = '0;
        alloc_tos_i  = '0;
        ret_vld_i    = 1'b0;
        mis_vld_i    = 1'b0;
        mis_tag_i    = '0;
        mis_rasctl_i = '0;
        mis_raddr_i  = '0;
        flush_i      = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic alloc_one(input logic [3:0] p, input logic [63:0] t);
        alloc_vld_i = 1'b1;
        alloc_ptr_i = p;
        alloc_tos_i = t;
        tick();
        idle_in();
    endtask

    task automatic mis_one(input logic [2:0] tag, input logic [1:0] ctl, input logic [63:0] ra);
        mis_vld_i    = 1'b1;
        mis_tag_i    = tag;
        mis_rasctl_i = ctl;
        mis_raddr_i  = ra;
        tick();
        idle_in();
    endtask

    task automatic flush_one();
        flush_i = 1'b1;
        tick();
        idle_in();
    endtask

    initial begin
        idle_in();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_alloc_rdy", 64'(alloc_rdy_o), 64'd1);
        chk("rst_mis_rdy",   64'(mis_rdy_o),   64'd1);
        chk("rst_tag",       64'(alloc_tag_o), 64'd0);
        chk("rst_cnt",       64'(cnt_o),       64'd0);
        chk("rst_stall",     64'(stall_o),     64'd0);
        chk("rst_we",        64'(rep_we_o),    64'd0);
        chk("rst_vld",       64'(rep_vld_o),   64'd0);
        chk("rst_addr",      64'(rep_addr_o),  64'd0);
        chk("rst_data",      rep_data_o,       64'd0);
        chk("rst_ptr",       64'(rep_ptr_o),   64'd0);
        tick();
        reset = 1'b0;

        // fill the queue
        for (int i = 0; i < 8; i++) begin
            alloc_vld_i = 1'b1;
            alloc_ptr_i = 4'(i);
            alloc_tos_i = 64'h100 + 64'(i);
            @(negedge clock);
            chk("fill_tag", 64'(alloc_tag_o), 64'(i));
            chk("fill_rdy", 64'(alloc_rdy_o), 64'd1);
            tick();
        end
        @(negedge clock);
        chk("full_cnt", 64'(cnt_o), 64'd8);
        chk("full_rdy", 64'(alloc_rdy_o), 64'd0);
        tick();
        idle_in();

        // retire three, refill across the wrap
        for (int i = 0; i < 3; i++) begin
            ret_vld_i = 1'b1;
            tick();
        end
        idle_in();
        for (int i = 0; i < 3; i++) begin
            alloc_vld_i = 1'b1;
            alloc_ptr_i = 4'(i + 8);
            alloc_tos_i = 64'h200 + 64'(i);
            @(negedge clock);
            chk("wrap_tag", 64'(alloc_tag_o), 64'(i));
            tick();
        end
        idle_in();
        @(negedge clock);
        chk("wrap_cnt", 64'(cnt_o), 64'd8);

        // retire on empty queue
        flush_one();
        ret_vld_i = 1'b1;
        tick();
        idle_in();
        @(negedge clock);
        chk("empty_ret_cnt", 64'(cnt_o), 64'd0);

        // pop repair
        for (int i = 0; i < 5; i++)
            alloc_one((i == 2) ? 4'd0 : 4'(i + 4), (i == 2) ? 64'hA5 : 64'h300 + 64'(i));
        mis_one(3'd2, 2'b10, 64'h0);
        @(negedge clock);
        chk("pop_we",    64'(rep_we_o),   64'd1);
        chk("pop_addr",  64'(rep_addr_o), 64'd0);
        chk("pop_data",  rep_data_o,      64'hA5);
        chk("pop_vld",   64'(rep_vld_o),  64'd1);
        chk("pop_ptr",   64'(rep_ptr_o),  64'd15);
        chk("pop_stall", 64'(stall_o),    64'd1);
        chk("pop_cnt",   64'(cnt_o),      64'd3);
        tick();
        @(negedge clock);
        chk("pop_stall_end", 64'(stall_o), 64'd0);

        // push repair with pointer wrap 15 -> 0
        flush_one();
        alloc_one(4'd15, 64'h77);
        mis_one(3'd0, 2'b01, 64'h1000);
        @(negedge clock);
        chk("push_r_we",    64'(rep_we_o),   64'd1);
        chk("push_r_addr",  64'(rep_addr_o), 64'd15);
        chk("push_r_data",  rep_data_o,      64'h77);
        chk("push_r_vld",   64'(rep_vld_o),  64'd0);
        chk("push_r_stall", 64'(stall_o),    64'd1);
        tick();
        @(negedge clock);
        chk("push_f_we",    64'(rep_we_o),   64'd1);
        chk("push_f_addr",  64'(rep_addr_o), 64'd0);
        chk("push_f_data",  rep_data_o,      64'h1000);
        chk("push_f_vld",   64'(rep_vld_o),  64'd1);
        chk("push_f_ptr",   64'(rep_ptr_o),  64'd0);
        chk("push_f_stall", 64'(stall_o),    64'd1);
        tick();
        @(negedge clock);
        chk("push_stall_end", 64'(stall_o), 64'd0);
        chk("push_cnt",       64'(cnt_o),   64'd1);

        // mispredict with simultaneous alloc, then flush during RESTORE
        mis_vld_i    = 1'b1;
        mis_tag_i    = 3'd0;
        mis_rasctl_i = 2'b01;
        mis_raddr_i  = 64'h2000;
        alloc_vld_i  = 1'b1;
        @(negedge clock);
        chk("coll_alloc_rdy", 64'(alloc_rdy_o), 64'd0);
        tick();
        idle_in();
        flush_i = 1'b1;
        @(negedge clock);
        chk("fl_we",  64'(rep_we_o),  64'd0);
        chk("fl_vld", 64'(rep_vld_o), 64'd0);
        tick();
        idle_in();
        @(negedge clock);
        chk("fl_stall", 64'(stall_o),  64'd0);
        chk("fl_we2",   64'(rep_we_o), 64'd0);
        chk("fl_cnt",   64'(cnt_o),    64'd0);

        // invalid tag
        alloc_one(4'd1, 64'h11);
        alloc_one(4'd2, 64'h22);
        mis_one(3'd5, 2'b01, 64'h3000);
        @(negedge clock);
        chk("inv_stall", 64'(stall_o),     64'd0);
        chk("inv_cnt",   64'(cnt_o),       64'd2);
        chk("inv_tag",   64'(alloc_tag_o), 64'd2);

        // reset in the middle of a repair
        mis_one(3'd1, 2'b11, 64'h4000);
        reset = 1'b1;
        #1;
        chk("mrst_we",    64'(rep_we_o), 64'd0);
        chk("mrst_stall", 64'(stall_o),  64'd0);
        chk("mrst_cnt",   64'(cnt_o),    64'd0);
        tick();
        reset = 1'b0;

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            idle_in();
            alloc_vld_i = ($urandom_range(1) == 1);
            alloc_ptr_i = 4'($urandom_range(15));
            alloc_tos_i = {$urandom(), $urandom()};
            ret_vld_i   = ($urandom_range(9) < 3);
            if ($urandom_range(7) == 0) begin
                mis_vld_i    = 1'b1;
                if (q.size() > 0 && $urandom_range(3) != 0)
                    mis_tag_i = 3'(q[$urandom_range(q.size() - 1)].tag);
                else
                    mis_tag_i = 3'($urandom_range(7));
                mis_rasctl_i = 2'($urandom_range(3));
                mis_raddr_i  = {$urandom(), $urandom()};
            end
            flush_i = ($urandom_range(49) == 0);
            tick();
        end
        idle_in();
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
